// File: rtl/synthetic_6_valve_sequencer_if.sv
// Route-command handshake and valve-drive bundle between the host/scheduler
// and the valve sequencer.
interface synthetic_6_valve_sequencer_if #(
  parameter int NUM_VALVES = 88,
  parameter int DWELL_W    = 24
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [NUM_VALVES-1:0] cmd_mask;
  logic [DWELL_W-1:0]    cmd_dwell;
  logic                  abort;
  logic [NUM_VALVES-1:0] valve_open;
  logic                  flow_en;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output cmd_valid, cmd_mask, cmd_dwell, abort,
    input  cmd_ready, valve_open, flow_en, busy, done, aborted
  );

  modport slave (
    input  cmd_valid, cmd_mask, cmd_dwell, abort,
    output cmd_ready, valve_open, flow_en, busy, done, aborted
  );
endinterface

// File: rtl/synthetic_6_valve_sequencer.sv
// Break-before-make valve sequencer: close dropped valves, settle, open new
// valves, settle, then enable pressure flow for the commanded dwell.
module synthetic_6_valve_sequencer #(
  parameter int NUM_VALVES   = 88,
  parameter int CNT_W        = 16,
  parameter int CLOSE_CYCLES = 1000,
  parameter int OPEN_CYCLES  = 1000,
  parameter int DWELL_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  synthetic_6_valve_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLOSE = 3'd1;
  localparam logic [2:0] S_OPEN  = 3'd2;
  localparam logic [2:0] S_DWELL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  localparam logic [CNT_W-1:0]   CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  logic [2:0]            state_q, state_d;
  logic [NUM_VALVES-1:0] valve_q, valve_d;
  logic [NUM_VALVES-1:0] mask_q, mask_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DWELL_W-1:0]    dcnt_q, dcnt_d;
  logic                  flow_q, flow_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic                  accept;
  logic                  go_open, go_dwell;
  logic [NUM_VALVES-1:0] mask_use;
  logic [DWELL_W-1:0]    dwell_use;

  assign bus.cmd_ready  = (state_q == S_IDLE) && !bus.abort;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.valve_open = valve_q;
  assign bus.flow_en    = flow_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d   = state_q;
    valve_d   = valve_q;
    mask_d    = mask_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    flow_d    = flow_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    go_open   = 1'b0;
    go_dwell  = 1'b0;
    mask_use  = mask_q;
    dwell_use = dwell_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mask_d    = bus.cmd_mask;
          dwell_d   = bus.cmd_dwell;
          mask_use  = bus.cmd_mask;
          dwell_use = bus.cmd_dwell;
          if ((valve_q & ~bus.cmd_mask) != '0) begin
            valve_d = valve_q & bus.cmd_mask;
            cnt_d   = CLOSE_LOAD;
            state_d = S_CLOSE;
          end else begin
            go_open = 1'b1;
          end
        end
      end
      S_CLOSE: begin
        if (bus.abort)         state_d = S_ABORT;
        else if (cnt_q == '0)  go_open = 1'b1;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      S_OPEN: begin
        if (bus.abort)         state_d  = S_ABORT;
        else if (cnt_q == '0)  go_dwell = 1'b1;
        else                   cnt_d    = cnt_q - 1'b1;
      end
      S_DWELL: begin
        if (bus.abort) begin
          state_d = S_ABORT;
        end else if (dcnt_q == '0) begin
          flow_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          dcnt_d = dcnt_q - DWELL_ONE;
        end
      end
      S_DONE: begin
        state_d = bus.abort ? S_ABORT : S_IDLE;
      end
      S_ABORT: begin
        if (cnt_q == '0) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entry rules cascade so skipped phases cost no cycles.
    if (go_open) begin
      if ((mask_use & ~valve_q) != '0) begin
        valve_d = mask_use;
        cnt_d   = OPEN_LOAD;
        state_d = S_OPEN;
      end else begin
        go_dwell = 1'b1;
      end
    end
    if (go_dwell) begin
      if (dwell_use != '0) begin
        flow_d  = 1'b1;
        dcnt_d  = dwell_use - DWELL_ONE;
        state_d = S_DWELL;
      end else begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end

    // Abort handling applies to every non-IDLE state except ABORT itself.
    if (state_d == S_ABORT && state_q != S_ABORT) begin
      valve_d = '0;
      flow_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = CLOSE_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valve_q   <= '0;
      mask_q    <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      flow_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valve_q   <= valve_d;
      mask_q    <= mask_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      flow_q    <= flow_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_synthetic_6_valve_sequencer.sv
// Directed bench for the valve sequencer with short settle times
// (CLOSE_CYCLES=4, OPEN_CYCLES=3).
module tb_synthetic_6_valve_sequencer;

  localparam int NV = 88;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt;
  logic [NV-1:0] big_m;

  always #5 clk = ~clk;

  synthetic_6_valve_sequencer_if #(.NUM_VALVES(NV), .DWELL_W(DW)) bus ();

  synthetic_6_valve_sequencer #(
    .NUM_VALVES(NV), .CNT_W(16), .CLOSE_CYCLES(4), .OPEN_CYCLES(3), .DWELL_W(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NV-1:0] m, input logic [DW-1:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_mask  = m;
    bus.cmd_dwell = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Counts consecutive cycles with flow_en high, bounded.
  task automatic count_flow(output int n);
    n = 0;
    for (int i = 0; i < 40 && bus.flow_en; i++) begin
      n++;
      tick();
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mask  = '0;
    bus.cmd_dwell = '0;
    bus.abort     = 1'b0;
    tick();
    tick();
    chk("rst_valve", bus.valve_open, 0);
    chk("rst_flow", bus.flow_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aborted", bus.aborted, 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", bus.cmd_ready, 1);

    // Route 1: M=0x5, D=5 from all-closed: CLOSE skipped.
    send(88'h5, 24'd5);
    chk("r1_valve", bus.valve_open, 88'h5);
    chk("r1_ready_low", bus.cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("r1_open_noflow", bus.flow_en, 0);
      tick();
    end
    count_flow(cnt);
    chk("r1_flow_len", cnt, 5);
    chk("r1_done", bus.done, 1);
    tick();
    chk("r1_done_1cyc", bus.done, 0);
    chk("r1_ready", bus.cmd_ready, 1);
    chk("r1_hold", bus.valve_open, 88'h5);

    // Route 2: M=0x6, D=2: break-before-make.
    send(88'h6, 24'd2);
    for (int i = 0; i < 4; i++) begin
      chk("r2_close_valve", bus.valve_open, 88'h4);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("r2_open_valve", bus.valve_open, 88'h6);
      chk("r2_open_noflow", bus.flow_en, 0);
      tick();
    end
    count_flow(cnt);
    chk("r2_flow_len", cnt, 2);
    chk("r2_done", bus.done, 1);
    tick();
    chk("r2_idle", bus.busy, 0);

    // Route 3: same mask, D=0.
    send(88'h6, 24'd0);
    chk("r3_done", bus.done, 1);
    chk("r3_busy", bus.busy, 1);
    chk("r3_valve", bus.valve_open, 88'h6);
    tick();
    chk("r3_done_off", bus.done, 0);
    chk("r3_busy_off", bus.busy, 0);

    // Route 4: D=10, abort in 3rd DWELL cycle.
    send(88'h6, 24'd10);
    chk("r4_flow", bus.flow_en, 1);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    chk("r4_ab_valve", bus.valve_open, 0);
    chk("r4_ab_flow", bus.flow_en, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bus.abort = 1'b0;
      if (bus.busy && !bus.aborted && !bus.done) cnt++;
      tick();
    end
    chk("r4_abort_len", cnt, 4);
    chk("r4_aborted", bus.aborted, 1);
    chk("r4_no_done", bus.done, 0);
    chk("r4_ready", bus.cmd_ready, 1);
    tick();
    chk("r4_aborted_1cyc", bus.aborted, 0);

    // Route 5: cmd_valid held while busy, mask toggling.
    bus.cmd_valid = 1'b1;
    bus.cmd_mask  = 88'h3;
    bus.cmd_dwell = 24'd1;
    tick();
    cnt = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      cnt++;
      chk("r5_valve_stable", bus.valve_open, 88'h3);
      bus.cmd_mask = (i % 2 == 0) ? 88'hF0 : 88'hF00;
      tick();
    end
    chk("r5_busy_len", cnt, 5);
    bus.abort = 1'b1;
    #1;
    chk("r5_abort_ready", bus.cmd_ready, 0);
    tick();
    chk("r5_blocked", bus.busy, 0);
    tick();
    chk("r5_blocked2", bus.valve_open, 88'h3);
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;

    // Route 6: async reset mid-OPEN, then a normal route.
    send(88'h33, 24'd1);
    chk("r6_open", bus.valve_open, 88'h33);
    tick();
    rst = 1'b1;
    #1;
    chk("r6_async_valve", bus.valve_open, 0);
    chk("r6_async_flow", bus.flow_en, 0);
    chk("r6_async_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    big_m = '0;
    big_m[87] = 1'b1;
    big_m[0]  = 1'b1;
    send(big_m, 24'd1);
    chk("r6_valve_hi", bus.valve_open, big_m);
    tick();
    tick();
    tick();
    count_flow(cnt);
    chk("r6_flow_len", cnt, 1);
    chk("r6_done", bus.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/synthetic_6_valve_sequencer.md
Name: synthetic_6_valve_sequencer

Overview:
- Control-layer sequencer for the Planar_Synthetic_6 flow network. It drives the per-port valves of the network's 17 three-way and 5 four-way switches.
- It accepts route commands (a target valve-open mask plus a dwell time) over a valid/ready handshake.
- It applies each route break-before-make: close the valves being dropped, settle, open the new valves, settle, then enable pressure flow for the dwell period.
- It sits between the host/scheduler and the valve driver pins, i.e. it is the actuation end of the flow netlist.

Parameters:
- NUM_VALVES, 88, valve count (22 switches x 4 ports); bit 4*s+p is switch s, port p.
- CNT_W, 16, width of the settle counter.
- CLOSE_CYCLES, 1000, settle cycles after closing valves; range 1..2^CNT_W-1.
- OPEN_CYCLES, 1000, settle cycles after opening valves; range 1..2^CNT_W-1.
- DWELL_W, 24, width of the dwell field.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; asynchronous, active-high.
- cmd_valid, input, 1, route command valid.
- cmd_ready, output, 1, sequencer can accept a command.
- cmd_mask, input, NUM_VALVES, target valve-open mask (1 = open).
- cmd_dwell, input, DWELL_W, number of flow-enabled cycles.
- abort, input, 1, request to stop the current route and close all valves.
- valve_open, output, NUM_VALVES, registered valve drive (1 = open).
- flow_en, output, 1, pressure source enable; high only during DWELL.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse when a route completes normally.
- aborted, output, 1, one-cycle pulse when abort handling completes.

Behaviour:
- Reset values: valve_open=0, flow_en=0, done=0, aborted=0, busy=0, state=IDLE, counter=0, latched mask/dwell=0.
- The reset is asynchronous, so outputs clear immediately when rst asserts, including mid-route.
- All outputs are registered except cmd_ready and busy, which decode state.
- cmd_ready = (state==IDLE) && !abort.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready. The sequencer latches mask M and dwell D.
- cmd_mask and cmd_dwell may change while cmd_ready is low; they are ignored.
- States: IDLE, CLOSE, OPEN, DWELL, DONE, ABORT.
- IDLE, on accept:
  - drop = valve_open & ~M.
  - If drop != 0: valve_open <= valve_open & M, counter <= CLOSE_CYCLES-1, go to CLOSE.
  - Otherwise skip CLOSE and apply the OPEN entry rule below in the same edge.
- CLOSE: decrement the counter. When it reaches 0, apply the OPEN entry rule.
  - Residency is exactly CLOSE_CYCLES cycles.
- OPEN entry rule:
  - add = M & ~valve_open.
  - If add != 0: valve_open <= M, counter <= OPEN_CYCLES-1, go to OPEN.
  - Otherwise skip OPEN and apply the DWELL entry rule.
- OPEN: decrement the counter. When it reaches 0, apply the DWELL entry rule.
  - Residency is exactly OPEN_CYCLES cycles.
- DWELL entry rule:
  - If D != 0: flow_en <= 1, dwell counter <= D-1, go to DWELL.
  - If D == 0: go to DONE.
- DWELL: flow_en stays high for exactly D cycles. On the last cycle, flow_en <= 0 and the state goes to DONE.
- DONE: done=1 for one cycle, then IDLE. valve_open keeps M (the route is held until the next command or abort).
- A command with M equal to the current valve_open and D=0 goes IDLE -> DONE -> IDLE. done pulses 1 cycle after accept.
- A command with M=0 closes all valves: CLOSE (if any valve was open), then DWELL/DONE as usual.
- Abort:
  - Sampled in CLOSE, OPEN, DWELL or DONE.
  - Next edge: valve_open <= 0, flow_en <= 0, counter <= CLOSE_CYCLES-1, go to ABORT. done is not pulsed.
  - Abort has priority over counter expiry in the same cycle.
  - ABORT: count CLOSE_CYCLES cycles, then aborted=1 for one cycle while moving to IDLE.
  - Abort asserted during ABORT is ignored.
  - Abort in IDLE: no state change, but it blocks acceptance (cmd_ready low).
- Counter arithmetic: unsigned, no wrap. Loaded only at state entry; never decremented below 0.

Test Plan:
- Params CLOSE_CYCLES=4, OPEN_CYCLES=3, NUM_VALVES=88.
- From reset, accept M=0x...0005 (bits 0,2), D=5:
  - CLOSE is skipped.
  - valve_open=0x5 one cycle after accept, and OPEN lasts 3 cycles.
  - flow_en is high for exactly 5 cycles.
  - done pulses 1 cycle, then cmd_ready=1.
- With valve_open=0x5, accept M=0x6, D=2:
  - Cycle after accept, valve_open=0x4 for 4 cycles.
  - Then valve_open=0x6 for the 3-cycle OPEN.
  - Then flow_en is high for 2 cycles, then done.
- With valve_open=0x6, accept M=0x6, D=0: no valve change, done pulses 1 cycle after accept, busy high exactly 1 cycle.
- Abort at the 3rd DWELL cycle of a D=10 route:
  - Next cycle valve_open=0 and flow_en=0.
  - ABORT lasts 4 cycles, then aborted=1, done never asserts, and cmd_ready returns.
- Hold cmd_valid=1 while busy and toggle cmd_mask:
  - No second accept until IDLE.
  - abort=1 in IDLE with cmd_valid=1 blocks acceptance.
- Assert rst mid-OPEN: valve_open, flow_en and busy go to 0 asynchronously, before the next clk edge. After release, a new command runs normally.
